// File: rtl/uart_word_interface.sv
`default_nettype none
// ============================================================================
// Module   : uart_word_interface
// Purpose  : Bridges a UART byte interface to 32-bit words. RX packs bytes
//            LSB-first with an idle timeout; TX unpacks a word into four
//            start/done byte transfers.
// Revision : 1.0 - initial release
// ============================================================================
module uart_word_interface #(
    parameter int NB_BYTE        = 8,
    parameter int NB_WORD        = 32,
    parameter int TIMEOUT_CYCLES = 4_500_000
) (
    input  logic               clk,
    input  logic               i_rst,
    // UART receiver side
    input  logic               i_rx_done,
    input  logic [NB_BYTE-1:0] i_rx_data,
    // UART transmitter side
    output logic               o_tx_start,
    output logic [NB_BYTE-1:0] o_tx_data,
    input  logic               i_tx_done,
    // System side
    output logic [NB_WORD-1:0] o_word,
    output logic               o_word_valid,
    output logic               o_rx_timeout,
    input  logic [NB_WORD-1:0] i_tx_word,
    input  logic               i_tx_word_valid,
    output logic               o_tx_ready
);

    localparam int c_LANES = NB_WORD / NB_BYTE;
    localparam int c_CNT_W = (c_LANES > 1) ? $clog2(c_LANES) : 1;
    localparam int c_TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(c_LANES - 1);
    localparam logic [c_TO_W-1:0]  c_TO_LAST  = c_TO_W'(TIMEOUT_CYCLES - 1);

    // ------------------------------------------------------------------
    // RX word assembly
    // ------------------------------------------------------------------
    logic [c_CNT_W-1:0] r_rx_cnt;
    logic [c_TO_W-1:0]  r_to_cnt;
    logic [NB_WORD-1:0] r_shreg;
    logic [NB_WORD-1:0] w_word_next;

    // Completed word includes the byte arriving this cycle in its lane.
    always_comb begin
        w_word_next = r_shreg;
        w_word_next[r_rx_cnt*NB_BYTE +: NB_BYTE] = i_rx_data;
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_rx_cnt     <= '0;
            r_to_cnt     <= '0;
            r_shreg      <= '0;
            o_word       <= '0;
            o_word_valid <= 1'b0;
            o_rx_timeout <= 1'b0;
        end else begin
            o_word_valid <= 1'b0;
            o_rx_timeout <= 1'b0;
            if (i_rx_done) begin
                // A byte always beats a coincident timeout.
                r_shreg  <= w_word_next;
                r_to_cnt <= '0;
                if (r_rx_cnt == c_CNT_LAST) begin
                    o_word       <= w_word_next;
                    o_word_valid <= 1'b1;
                    r_rx_cnt     <= '0;
                end else begin
                    r_rx_cnt <= r_rx_cnt + 1'b1;
                end
            end else if (r_rx_cnt == '0) begin
                r_to_cnt <= '0;
            end else if (r_to_cnt == c_TO_LAST) begin
                r_rx_cnt     <= '0;
                r_to_cnt     <= '0;
                o_rx_timeout <= 1'b1;
            end else begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // TX word serialisation
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2
    } tx_state_t;

    tx_state_t          r_tx_state;
    logic [NB_WORD-1:0] r_tx_word;
    logic [c_CNT_W-1:0] r_tx_idx;
    logic [c_CNT_W-1:0] w_tx_idx_next;

    assign w_tx_idx_next = r_tx_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_tx_state <= S_IDLE;
            r_tx_word  <= '0;
            r_tx_idx   <= '0;
            o_tx_start <= 1'b0;
            o_tx_data  <= '0;
            o_tx_ready <= 1'b1;
        end else begin
            case (r_tx_state)
                S_IDLE: begin
                    if (i_tx_word_valid) begin
                        r_tx_word  <= i_tx_word;
                        r_tx_idx   <= '0;
                        o_tx_start <= 1'b1;
                        o_tx_data  <= i_tx_word[NB_BYTE-1:0];
                        o_tx_ready <= 1'b0;
                        r_tx_state <= S_START;
                    end
                end
                S_START: begin
                    o_tx_start <= 1'b0;
                    r_tx_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (i_tx_done) begin
                        if (r_tx_idx == c_CNT_LAST) begin
                            o_tx_ready <= 1'b1;
                            r_tx_state <= S_IDLE;
                        end else begin
                            r_tx_idx   <= w_tx_idx_next;
                            o_tx_start <= 1'b1;
                            o_tx_data  <= r_tx_word[w_tx_idx_next*NB_BYTE +: NB_BYTE];
                            r_tx_state <= S_START;
                        end
                    end
                end
                default: begin
                    o_tx_start <= 1'b0;
                    o_tx_ready <= 1'b1;
                    r_tx_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_word_interface.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_word_interface
// Purpose  : Scoreboard bench for uart_word_interface with a word-level model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_uart_word_interface;

    localparam int T = 16;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_rx_done = 1'b0;
    logic [7:0]  i_rx_data = '0;
    logic        o_tx_start;
    logic [7:0]  o_tx_data;
    logic        i_tx_done = 1'b0;
    logic [31:0] o_word;
    logic        o_word_valid;
    logic        o_rx_timeout;
    logic [31:0] i_tx_word = '0;
    logic        i_tx_word_valid = 1'b0;
    logic        o_tx_ready;

    always #5 clk = ~clk;

    uart_word_interface #(
        .NB_BYTE(8), .NB_WORD(32), .TIMEOUT_CYCLES(T)
    ) dut (
        .clk(clk), .i_rst(i_rst),
        .i_rx_done(i_rx_done), .i_rx_data(i_rx_data),
        .o_tx_start(o_tx_start), .o_tx_data(o_tx_data), .i_tx_done(i_tx_done),
        .o_word(o_word), .o_word_valid(o_word_valid), .o_rx_timeout(o_rx_timeout),
        .i_tx_word(i_tx_word), .i_tx_word_valid(i_tx_word_valid), .o_tx_ready(o_tx_ready)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [31:0] val; int cyc; } exp_t;
    exp_t q_word[$];
    exp_t q_to[$];
    exp_t q_tx[$];
    exp_t me;
    logic [31:0] hold_word = '0;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic unexpected(input string name);
        n_checks++;
        $display("FAIL %s: unexpected pulse at cycle %0d", name, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops expectations whenever the DUT presents an event.
    always @(negedge clk) begin
        if (o_word_valid) begin
            if (q_word.size() == 0) unexpected("word_valid");
            else begin
                me = q_word.pop_front();
                check("word_value", o_word, me.val);
                check("word_cycle", 32'(cyc), 32'(me.cyc));
                hold_word = me.val;
            end
        end
        if (o_rx_timeout) begin
            if (q_to.size() == 0) unexpected("rx_timeout");
            else begin
                me = q_to.pop_front();
                check("timeout_cycle", 32'(cyc), 32'(me.cyc));
                check("timeout_word_hold", o_word, hold_word);
            end
        end
        if (o_tx_start) begin
            if (q_tx.size() == 0) unexpected("tx_start");
            else begin
                me = q_tx.pop_front();
                check("tx_byte", {24'h0, o_tx_data}, me.val);
                check("tx_start_cycle", 32'(cyc), 32'(me.cyc));
            end
        end
    end

    // RX reference: bytes pack LSB-first; a partial word is dropped once
    // more than T cycles pass after its last byte.
    int          rx_n = 0;
    int          rx_last = 0;
    logic [31:0] rx_part = '0;

    task automatic rx_cycle(input bit v, input logic [7:0] d);
        exp_t e;
        if (rx_n > 0 && cyc - rx_last == T + 1) begin
            e.val = '0; e.cyc = cyc;
            q_to.push_back(e);
            rx_n = 0;
        end
        i_rx_done = v;
        i_rx_data = v ? d : 8'($urandom);
        if (v) begin
            rx_part[rx_n*8 +: 8] = d;
            rx_n++;
            rx_last = cyc;
            if (rx_n == 4) begin
                e.val = rx_part; e.cyc = cyc + 1;
                q_word.push_back(e);
                rx_n = 0;
            end
        end
    endtask

    task automatic rx_idle(input int n);
        repeat (n) begin tick(); rx_cycle(1'b0, 8'h00); end
    endtask

    task automatic rx_byte(input logic [7:0] d);
        tick();
        rx_cycle(1'b1, d);
    endtask

    // TX driver: the transmitter model answers each start after d cycles.
    task automatic tx_send(input logic [31:0] w, input bit spur, input int dfix);
        int   s[4];
        int   d[4];
        int   k;
        int   tend;
        exp_t e;
        k = 0;
        tick();
        while (!o_tx_ready && k < 100) begin tick(); k++; end
        if (k >= 100) begin
            n_checks++;
            $display("FAIL tx_ready_wait: o_tx_ready stayed 0, expected 1");
            return;
        end
        for (int i = 0; i < 4; i++)
            d[i] = (dfix != 0) ? dfix : (spur ? int'($urandom_range(3, 12)) : int'($urandom_range(1, 12)));
        i_tx_word = w;
        i_tx_word_valid = 1'b1;
        s[0] = cyc + 1;
        for (int i = 1; i < 4; i++) s[i] = s[i-1] + d[i-1] + 1;
        for (int i = 0; i < 4; i++) begin
            e.val = {24'h0, w[i*8 +: 8]}; e.cyc = s[i];
            q_tx.push_back(e);
        end
        tend = s[3] + d[3];
        for (int t = s[0]; t <= tend; t++) begin
            tick();
            i_tx_word_valid = spur && (t == s[0] + 2);
            i_tx_word       = spur ? 32'h1111_1111 : $urandom;
            i_tx_done       = spur && (t == s[0]);
            for (int i = 0; i < 4; i++) begin
                if (t == s[i] + d[i]) begin
                    i_tx_done = 1'b1;
                    check("tx_data_stable", {24'h0, o_tx_data}, {24'h0, w[i*8 +: 8]});
                end
            end
            check("tx_ready_busy", {31'h0, o_tx_ready}, 32'h0);
        end
        tick();
        i_tx_done = 1'b0;
        i_tx_word_valid = 1'b0;
        check("tx_ready_back", {31'h0, o_tx_ready}, 32'h1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_word"},       o_word, 32'h0);
        check({tag, "_word_valid"}, {31'h0, o_word_valid}, 32'h0);
        check({tag, "_timeout"},    {31'h0, o_rx_timeout}, 32'h0);
        check({tag, "_tx_start"},   {31'h0, o_tx_start}, 32'h0);
        check({tag, "_tx_data"},    {24'h0, o_tx_data}, 32'h0);
        check({tag, "_tx_ready"},   {31'h0, o_tx_ready}, 32'h1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   n;
        repeat (3) tick();
        check_reset_outputs("reset");
        i_rst = 1'b0;

        // Directed word assembly alongside the directed TX word
        fork
            begin
                rx_byte(8'h78); rx_byte(8'h56); rx_byte(8'h34); rx_byte(8'h12);
                rx_idle(3);
            end
            tx_send(32'hDEAD_BEEF, 1'b0, 10);
        join

        // Timeout, recovery, exact-timeout byte, gap of T+1
        fork
            begin
                rx_byte(8'hAA); rx_byte(8'hBB); rx_idle(T + 4);
                rx_byte(8'h01); rx_byte(8'h02); rx_byte(8'h03); rx_byte(8'h04);
                rx_idle(2);
                rx_byte(8'hE1); rx_byte(8'hE2); rx_idle(T - 1);
                rx_byte(8'hE3); rx_byte(8'hE4); rx_idle(3);
                rx_byte(8'hF1); rx_idle(T);
                rx_byte(8'hF2); rx_byte(8'hF3); rx_byte(8'hF4); rx_byte(8'hF5);
                rx_idle(T + 2);
            end
            tx_send($urandom, 1'b1, 10);
        join

        // Randomised concurrent traffic
        fork
            begin
                repeat (40) begin
                    rx_idle($urandom_range(0, T + 3));
                    rx_byte(8'($urandom));
                end
                rx_idle(T + 3);
            end
            repeat (6) tx_send($urandom, 1'($urandom_range(0, 1)), 0);
        join

        // Reset during a partial RX word and during TX byte 1
        tick(); rx_cycle(1'b0, 8'h00);
        i_tx_word = 32'hCAFE_F00D; i_tx_word_valid = 1'b1;
        n = cyc;
        e.val = 32'h0D; e.cyc = n + 1; q_tx.push_back(e);
        e.val = 32'hF0; e.cyc = n + 5; q_tx.push_back(e);
        tick(); i_tx_word_valid = 1'b0; rx_cycle(1'b1, 8'h5A);
        tick(); rx_cycle(1'b1, 8'hC3);
        tick(); rx_cycle(1'b0, 8'h00);
        tick(); i_tx_done = 1'b1; rx_cycle(1'b0, 8'h00);
        tick(); i_tx_done = 1'b0; rx_cycle(1'b0, 8'h00);
        tick(); i_rst = 1'b1; rx_cycle(1'b0, 8'h00);
        tick(); i_rst = 1'b0;
        rx_n = 0;
        hold_word = '0;
        check_reset_outputs("midop_reset");
        rx_cycle(1'b0, 8'h00);

        // Recovery after reset
        fork
            begin
                rx_byte(8'h9A); rx_byte(8'hBC); rx_byte(8'hDE); rx_byte(8'hF0);
                rx_idle(3);
            end
            tx_send($urandom, 1'b0, 0);
        join

        repeat (5) tick();
        check("q_word_empty", 32'(q_word.size()), 32'h0);
        check("q_timeout_empty", 32'(q_to.size()), 32'h0);
        check("q_tx_empty", 32'(q_tx.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
